// File: rtl/muldiv_alu.sv
// Integer ALU with single-cycle logic/shift/multiply ops and a radix-2 restoring divider.
// Results are registered and presented with a valid/ready handshake; Flush aborts any pending work.
module muldiv_alu #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Flush,
   input  logic              InValid,
   output logic              InReady,
   input  logic [XLEN-1:0]   A,
   input  logic [XLEN-1:0]   B,
   input  logic [4:0]        ALUControl,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [XLEN-1:0]   ALUResult,
   output logic              Zero
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   localparam logic [4:0] OP_AND  = 5'b00000, OP_OR   = 5'b00001, OP_ADD  = 5'b00010,
                          OP_SUB  = 5'b00110, OP_SLT  = 5'b00111, OP_SLTU = 5'b01000,
                          OP_XOR  = 5'b01001, OP_SLL  = 5'b01010, OP_SRL  = 5'b01011,
                          OP_SRA  = 5'b01100, OP_NOR  = 5'b01101, OP_MUL  = 5'b10000,
                          OP_MULH = 5'b10001, OP_MULHSU = 5'b10010, OP_MULHU = 5'b10011,
                          OP_DIV  = 5'b10100, OP_DIVU = 5'b10101, OP_REM  = 5'b10110,
                          OP_REMU = 5'b10111;

   typedef enum logic [1:0] {IDLE, DIV_BUSY, DONE} state_t;

   state_t state, state_next;

   logic                accept;
   logic                is_div, div_signed, div_zero, div_ovf, div_iter, div_last;
   logic                a_neg, b_neg;
   logic [SHAMT_W-1:0]  shamt;
   logic [2*XLEN-1:0]   a_ext, b_ext, prod;
   logic [XLEN-1:0]     mul_res, div_quick, quick_res;
   logic [XLEN-1:0]     dvsr, quo, rem;
   logic                neg_q, neg_r, want_rem;
   logic [CNT_W-1:0]    cnt;
   logic [XLEN:0]       rem_shift, rem_diff;
   logic                take;
   logic [XLEN-1:0]     rem_step, quo_step, div_final;

   function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] x);
      return neg ? -x : x;
   endfunction

   assign InReady  = (state == IDLE) || ((state == DONE) && OutReady);
   assign OutValid = (state == DONE);
   assign accept   = InValid && InReady && !Flush;

   assign is_div     = (ALUControl[4:2] == 3'b101);
   assign div_signed = !ALUControl[0];
   assign div_zero   = (B == '0);
   assign div_ovf    = div_signed && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
   assign div_iter   = is_div && !div_zero && !div_ovf;
   assign a_neg      = div_signed && A[XLEN-1];
   assign b_neg      = div_signed && B[XLEN-1];
   assign div_quick  = div_zero ? (ALUControl[1] ? A : '1) : (ALUControl[1] ? '0 : A);

   // One shared 2*XLEN multiplier; operand extension selects the signedness flavour.
   assign a_ext   = {{XLEN{(ALUControl[1:0] != 2'b11) && A[XLEN-1]}}, A};
   assign b_ext   = {{XLEN{(ALUControl[1:0] == 2'b01) && B[XLEN-1]}}, B};
   assign prod    = a_ext * b_ext;
   assign mul_res = (ALUControl[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

   assign shamt = B[SHAMT_W-1:0];

   always_comb begin
      quick_res = '0;
      case (ALUControl)
         OP_AND:  quick_res = A & B;
         OP_OR:   quick_res = A | B;
         OP_ADD:  quick_res = A + B;
         OP_SUB:  quick_res = A - B;
         OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, (A < B)};
         OP_XOR:  quick_res = A ^ B;
         OP_SLL:  quick_res = A << shamt;
         OP_SRL:  quick_res = A >> shamt;
         OP_SRA:  quick_res = $unsigned($signed(A) >>> shamt);
         OP_NOR:  quick_res = ~(A | B);
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: quick_res = mul_res;
         OP_DIV, OP_DIVU, OP_REM, OP_REMU:     quick_res = div_quick;
         default: quick_res = '0;
      endcase
   end

   // Restoring step on magnitudes: the quotient register shifts its dividend bits out as quotient bits enter.
   assign rem_shift = {rem, quo[XLEN-1]};
   assign rem_diff  = rem_shift - {1'b0, dvsr};
   assign take      = !rem_diff[XLEN];
   assign rem_step  = take ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
   assign quo_step  = {quo[XLEN-2:0], take};
   assign div_final = want_rem ? neg_if(neg_r, rem_step) : neg_if(neg_q, quo_step);
   assign div_last  = (state == DIV_BUSY) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (Flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:     if (accept) state_next = div_iter ? DIV_BUSY : DONE;
            DIV_BUSY: if (div_last) state_next = DONE;
            DONE: begin
               if (accept)        state_next = div_iter ? DIV_BUSY : DONE;
               else if (OutReady) state_next = IDLE;
            end
            default:  state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         dvsr     <= neg_if(b_neg, B);
         quo      <= neg_if(a_neg, A);
         rem      <= '0;
         neg_q    <= a_neg ^ b_neg;
         neg_r    <= a_neg;
         want_rem <= ALUControl[1];
      end else if (state == DIV_BUSY) begin
         rem <= rem_step;
         quo <= quo_step;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         ALUResult <= '0;
         Zero      <= 1'b1;
      end else if (Flush) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= '0;
         if (!div_iter) begin
            ALUResult <= quick_res;
            Zero      <= (quick_res == '0);
         end
      end else if (state == DIV_BUSY) begin
         cnt <= cnt + 1'b1;
         if (div_last) begin
            ALUResult <= div_final;
            Zero      <= (div_final == '0);
         end
      end
   end

endmodule

// File: doc/muldiv_alu.md
MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 Parameter SHAMT_W, default $clog2(XLEN), number of B LSBs used as shift amount.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 Flush  input  1  synchronous abort of any in-flight or pending result.
REQ-006 InValid  input  1  operation request valid.
REQ-007 InReady  output  1  unit accepts a request this cycle.
REQ-008 A, B  input  XLEN each  operands (A = rs1, B = rs2/immediate).
REQ-009 ALUControl  input  5  operation code, per REQ-012.
REQ-010 OutValid  output  1  ALUResult/Zero valid.
REQ-011 OutReady  input  1  consumer accepts result this cycle.
REQ-011a ALUResult  output  XLEN  registered result; Zero  output  1  registered, high iff ALUResult == 0.

Function
REQ-012 Opcodes: 00000 AND, 00001 OR, 00010 ADD, 00110 SUB, 00111 SLT, 01000 SLTU, 01001 XOR, 01010 SLL, 01011 SRL, 01100 SRA, 01101 NOR, 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU; any other code yields result 0.
REQ-013 Request accepted in cycle T iff InValid && InReady && !Flush at the T rising edge.
REQ-014 Non-divide ops (incl. undefined codes): OutValid high from cycle T+1.
REQ-015 MUL returns low XLEN bits of product; MULH signed x signed, MULHSU signed A x unsigned B, MULHU unsigned x unsigned, each returning high XLEN bits of the 2*XLEN product; latency per REQ-014.
REQ-016 Shifts use B[SHAMT_W-1:0] only; SRA sign-fills from A[XLEN-1]; ADD/SUB wrap modulo 2^XLEN.
REQ-017 DIV/DIVU/REM/REMU: restoring radix-2 iteration, one quotient bit per cycle; OutValid high from cycle T+XLEN+1; DIV/REM truncate toward zero, remainder sign follows dividend.
REQ-018 Divide by zero (B == 0): quotient all ones, remainder = A; OutValid from T+1, no iteration.
REQ-019 Signed overflow (A = most negative, B = all ones, DIV/REM): quotient = A, remainder 0; OutValid from T+1.
REQ-020 States: IDLE, DIV_BUSY, DONE. IDLE -> DONE on accepted non-iterating op; IDLE -> DIV_BUSY on accepted iterating divide; DIV_BUSY -> DONE after XLEN iterations; DONE -> IDLE on OutReady with no new accept; DONE -> DONE/DIV_BUSY on OutReady with simultaneous accept.
REQ-021 InReady = (state == IDLE) || (state == DONE && OutReady); InReady low throughout DIV_BUSY.
REQ-022 While OutValid && !OutReady, ALUResult and Zero SHALL hold stable.
REQ-023 Operands and opcode captured at accept; later changes on A/B/ALUControl SHALL not affect the result.
REQ-024 Flush: next state IDLE, OutValid low next cycle, in-flight division and pending result discarded; a request presented in the same cycle is not accepted; Flush has priority over OutReady and InValid.

Reset
REQ-025 rst_n low at a rising edge: state IDLE, OutValid 0, ALUResult 0, Zero 1, iteration counter 0; InReady high from the first cycle after release.
REQ-026 Reset mid-division discards the operation; no OutValid pulse follows release.
REQ-027 Reset has priority over Flush and all handshakes.

Verification
REQ-028 XLEN=32: ADD A=0x7FFFFFFF, B=1, OutReady=1 -> cycle T+1 OutValid=1, ALUResult=0x80000000, Zero=0.
REQ-029 DIV A=-7 (0xFFFFFFF9), B=2 -> OutValid at T+33, ALUResult=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; InReady low cycles T+1..T+32.
REQ-030 DIVU A=5, B=0 -> T+1 ALUResult=0xFFFFFFFF; REM A=0x80000000, B=0xFFFFFFFF -> T+1 ALUResult=0, Zero=1.
REQ-031 MULH A=0x80000000, B=0x80000000 -> 0x40000000; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MUL same -> 0x00000001.
REQ-032 Back-to-back: SUB held with OutReady=0 for 3 cycles -> result stable, InReady low; OutReady=1 with new SLT A=-1, B=1 accepted same cycle -> next cycle ALUResult=1.
REQ-033 Flush at T+10 of DIVU, then rst_n low mid second DIVU -> no OutValid for either; next ADD completes normally at T'+1.
